// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the multiplier product.
// Latency: start sampled at edge E -> done pulse and new bcd visible after edge E+IN_W+1.
// Backpressure: none; start is ignored while busy, so the next start is accepted IN_W+2 cycles later.
//
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - asynchronous active-high reset
//   start - request conversion of bin (sampled only while idle)
//   bin   - unsigned binary input
//   busy  - conversion in progress
//   done  - one-cycle pulse, bcd just updated
//   bcd   - packed BCD result, ones digit in [3:0]
module product_bcd_converter #(
   parameter int IN_W   = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // The digit scratch must be able to hold the largest input value.
   if ((10 ** DIGITS) <= ((2 ** IN_W) - 1)) begin : g_width_check
      $error("product_bcd_converter: DIGITS too small for IN_W");
   end

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IN_W-1:0]  bin_q, bin_d;
   logic [BCD_W-1:0] scr_q, scr_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic [BCD_W-1:0] adj;

   // Add-3 correction on every digit before the shift; a corrected nibble
   // is at most 12, so the 4-bit add never carries out.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      assign adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? (scr_q[4*g +: 4] + 4'd3)
                                                        : scr_q[4*g +: 4];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d   = bin;
               scr_d   = '0;
               cnt_d   = CNT_W'(IN_W);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            {scr_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Result register only changes here, so bcd never shows partial values.
            bcd_d   = scr_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // busy is registered from the next state so it tracks state != IDLE.
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         scr_q   <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: reset, single conversions,
// ignored start while busy, reset mid-conversion and a back-to-back sweep.
module tb_product_bcd_converter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;

   int checks   = 0;
   int failures = 0;

   product_bcd_converter #(.IN_W(8), .DIGITS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      return 12'((h << 8) | (t << 4) | o);
   endfunction

   // One isolated conversion with latency, busy-length and hold checks.
   task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd);
      int          lat;
      int          busy_cyc;
      bit          hold_ok;
      logic [11:0] prev;
      @(negedge clk);
      prev  = bcd;
      start = 1'b1;
      bin   = v;
      @(posedge clk);
      #1;
      start    = 1'b0;
      bin      = v ^ 8'hA5;   // input may change after capture
      busy_cyc = busy ? 1 : 0;
      lat      = 0;
      hold_ok  = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
         if (busy) busy_cyc++;
         if (bcd !== prev) hold_ok = 1'b0;
      end
      check("latency", lat, 9);
      check("busy_cycles", busy_cyc, 9);
      check("bcd_hold", 32'(hold_ok), 1);
      check("bcd", 32'(bcd), 32'(exp_bcd));
      check("busy_at_done", 32'(busy), 0);
      @(posedge clk);
      #1;
      check("done_pulse_width", 32'(done), 0);
      check("bcd_keep", 32'(bcd), 32'(exp_bcd));
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int dones;
      int gap;
      int vals[$];

      rst   = 1'b1;
      start = 1'b0;
      bin   = 8'd0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_bcd",  32'(bcd), 0);
      rst = 1'b0;

      // 15*15
      convert(8'd225, 12'h225);

      // Async reset in idle clears bcd before any clock edge.
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_done", 32'(done), 0);
      check("async_rst_bcd",  32'(bcd), 0);
      @(negedge clk);
      rst = 1'b0;

      convert(8'd0,   12'h000);
      convert(8'd255, 12'h255);
      convert(8'd9,   12'h009);
      convert(8'd100, 12'h100);

      // start pulse during SHIFT must be ignored.
      @(negedge clk);
      start = 1'b1;
      bin   = 8'd42;
      @(posedge clk);
      #1;
      start = 1'b0;
      dones = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
         if (i == 3) begin
            start = 1'b1;
            bin   = 8'd7;
         end else begin
            start = 1'b0;
         end
      end
      check("ignore_start_dones", dones, 1);
      check("ignore_start_bcd", 32'(bcd), 32'h042);
      check("ignore_start_idle", 32'(busy), 0);

      // Reset in the middle of a conversion aborts it.
      @(negedge clk);
      start = 1'b1;
      bin   = 8'd200;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_bcd",  32'(bcd), 0);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_bcd_after", 32'(bcd), 0);
      convert(8'd56, 12'h056);

      // Back-to-back sweep with start held high: all bytes, then all 4x4 products.
      for (int v = 0; v < 256; v++) vals.push_back(v);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++) vals.push_back(a * b);

      @(negedge clk);
      bin   = 8'(vals[0]);
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < vals.size(); k++) begin
         gap = 0;
         for (int i = 1; i <= 15; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
               gap = i;
               break;
            end
         end
         check($sformatf("sweep_gap[%0d]", k), gap, (k == 0) ? 9 : 10);
         check($sformatf("sweep_bcd[%0d]", vals[k]), 32'(bcd), 32'(to_bcd(vals[k])));
         if (k + 1 < vals.size()) bin = 8'(vals[k+1]);
      end
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("sweep_end_idle", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
